mixer_multi: RTL and testbench

Parametrised stereo sound mixer with N channels, the successor to the fixed beeper/tape/soundrive mixer. It time-multiplexes one adder across NUM_CH sample channels, each with its own volume and left/right panning. The stereo sums drive two first-order delta-sigma 1-bit DACs on snd_l and snd_r. It sits between the sound sources (beeper, tape, covox/soundrive, future AY-in-CPLD) and the DAC pins, clocked by clk28.

---
 rtl/mixer_multi_pkg.sv | 15 +
 rtl/mixer_multi_if.sv | 27 ++
 rtl/mixer_multi_dsm1.sv | 32 +++
 rtl/mixer_multi.sv | 140 ++++++++++++++
 tb/tb_mixer_multi.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mixer_multi_pkg.sv
// Shared types and constants for the N-channel stereo mixer.
// Build option: MIXER_SOFTMUTE_EN (see mixer_multi.sv).
package mixer_multi_pkg;

    typedef enum logic [1:0] {
        VOL_MUTE    = 2'd0,
        VOL_QUARTER = 2'd1,
        VOL_HALF    = 2'd2,
        VOL_FULL    = 2'd3
    } vol_t;

    localparam int unsigned PAN_L_BIT = 0;
    localparam int unsigned PAN_R_BIT = 1;

endpackage

// File: rtl/mixer_multi_if.sv
// Source-side bus of the mixer: channel samples/volume/pan in, mixes and DAC bits out.
interface mixer_multi_if #(
    parameter  int NUM_CH   = 6,
    parameter  int SAMPLE_W = 8,
    localparam int ACC_W    = SAMPLE_W + $clog2(NUM_CH)
);
    logic [NUM_CH*SAMPLE_W-1:0] ch_data;
    logic [NUM_CH*2-1:0]        ch_vol;
    logic [NUM_CH*2-1:0]        ch_pan;
    logic                       mute;
    logic [ACC_W-1:0]           mix_l;
    logic [ACC_W-1:0]           mix_r;
    logic                       mix_valid;
    logic                       dac_l;
    logic                       dac_r;

    modport master (
        output ch_data, ch_vol, ch_pan, mute,
        input  mix_l, mix_r, mix_valid, dac_l, dac_r
    );

    modport slave (
        input  ch_data, ch_vol, ch_pan, mute,
        output mix_l, mix_r, mix_valid, dac_l, dac_r
    );

endinterface

// File: rtl/mixer_multi_dsm1.sv
// First-order delta-sigma 1-bit DAC: carry of a W-bit phase accumulator, registered.
module dsm1 #(
    parameter int W = 11
) (
    input  logic         clk28,
    input  logic         usrrst_n,
    input  logic [W-1:0] in,
    output logic         out
);

    // Only the low W bits of the running sum are kept; its carry goes straight to out_q.
    logic [W-1:0] s_q;
    logic [W:0]   s_d;
    logic         out_q;

    always_comb begin
        s_d = {1'b0, s_q} + {1'b0, in};
    end

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            s_q   <= '0;
            out_q <= 1'b0;
        end else begin
            s_q   <= s_d[W-1:0];
            out_q <= s_d[W];
        end
    end

    assign out = out_q;

endmodule

// File: rtl/mixer_multi.sv
// Time-multiplexed N-channel stereo mixer feeding two delta-sigma DACs.
// Build option: define MIXER_SOFTMUTE_EN for the ramped master soft-mute on the DAC path.
module mixer_multi
    import mixer_multi_pkg::*;
#(
    parameter  int NUM_CH   = 6,
    parameter  int SAMPLE_W = 8,
    parameter  int VOL_W    = 2,
    localparam int ACC_W    = SAMPLE_W + $clog2(NUM_CH)
) (
    input  logic            clk28,
    input  logic            usrrst_n,
    mixer_multi_if.slave    bus
);

    localparam int CNT_W = $clog2(NUM_CH + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_l_q, acc_l_d;
    logic [ACC_W-1:0]    acc_r_q, acc_r_d;
    logic [ACC_W-1:0]    mix_l_q, mix_l_d;
    logic [ACC_W-1:0]    mix_r_q, mix_r_d;
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] scaled;
    logic [1:0]          pan;
    vol_t                vol;
    logic                latch;
    logic [ACC_W-1:0]    dsm_in_l, dsm_in_r;
    logic                dac_l_w, dac_r_w;

    assign latch = (cnt_q == CNT_W'(NUM_CH));

    always_comb begin
        sample = '0;
        vol    = VOL_MUTE;
        pan    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                sample = bus.ch_data[i*SAMPLE_W +: SAMPLE_W];
                vol    = vol_t'(bus.ch_vol[i*VOL_W +: VOL_W]);
                pan    = bus.ch_pan[i*2 +: 2];
            end
        end
        case (vol)
            VOL_FULL:    scaled = sample;
            VOL_HALF:    scaled = sample >> 1;
            VOL_QUARTER: scaled = sample >> 2;
            default:     scaled = '0;
        endcase
    end

    always_comb begin
        cnt_d   = latch ? '0 : cnt_q + 1'b1;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        mix_l_d = mix_l_q;
        mix_r_d = mix_r_q;
        if (latch) begin
            mix_l_d = acc_l_q;
            mix_r_d = acc_r_q;
            acc_l_d = '0;
            acc_r_d = '0;
        end else begin
            if (pan[PAN_L_BIT]) acc_l_d = acc_l_q + ACC_W'(scaled);
            if (pan[PAN_R_BIT]) acc_r_d = acc_r_q + ACC_W'(scaled);
        end
        // Strobe is registered so it is high exactly while the scan sits in the latch slot.
        valid_d = (cnt_d == CNT_W'(NUM_CH));
    end

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            cnt_q   <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            mix_l_q <= '0;
            mix_r_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            mix_l_q <= mix_l_d;
            mix_r_q <= mix_r_d;
            valid_q <= valid_d;
        end
    end

`ifdef MIXER_SOFTMUTE_EN
    localparam int G_W = $clog2(ACC_W + 1);

    logic [G_W-1:0] g_q, g_d;

    always_comb begin
        g_d = g_q;
        if (valid_q) begin
            if (bus.mute) begin
                if (g_q != G_W'(ACC_W)) g_d = g_q + 1'b1;
            end else begin
                if (g_q != '0) g_d = g_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) g_q <= G_W'(ACC_W);
        else           g_q <= g_d;
    end

    assign dsm_in_l = mix_l_q >> g_q;
    assign dsm_in_r = mix_r_q >> g_q;
`else
    logic unused_mute;
    assign unused_mute = bus.mute;
    assign dsm_in_l    = mix_l_q;
    assign dsm_in_r    = mix_r_q;
`endif

    dsm1 #(.W(ACC_W)) u_dsm_l (
        .clk28    (clk28),
        .usrrst_n (usrrst_n),
        .in       (dsm_in_l),
        .out      (dac_l_w)
    );

    dsm1 #(.W(ACC_W)) u_dsm_r (
        .clk28    (clk28),
        .usrrst_n (usrrst_n),
        .in       (dsm_in_r),
        .out      (dac_r_w)
    );

    assign bus.mix_l     = mix_l_q;
    assign bus.mix_r     = mix_r_q;
    assign bus.mix_valid = valid_q;
    assign bus.dac_l     = dac_l_w;
    assign bus.dac_r     = dac_r_w;

endmodule

// File: tb/tb_mixer_multi.sv
// Directed self-checking bench for mixer_multi (NUM_CH=6, SAMPLE_W=8, ACC_W=11).
module tb_mixer_multi;

    logic clk28;
    logic usrrst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   nl, nr, n;

    mixer_multi_if #(.NUM_CH(6), .SAMPLE_W(8)) bus ();

    mixer_multi #(.NUM_CH(6), .SAMPLE_W(8), .VOL_W(2)) dut (
        .clk28    (clk28),
        .usrrst_n (usrrst_n),
        .bus      (bus)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [7:0] d, input logic [1:0] v, input logic [1:0] p);
        bus.ch_data[i*8 +: 8] = d;
        bus.ch_vol[i*2 +: 2]  = v;
        bus.ch_pan[i*2 +: 2]  = p;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 6; i++) set_ch(i, 8'h00, 2'd0, 2'b00);
    endtask

    // Advance to the next negedge where mix_valid is high (bounded).
    task automatic wait_valid();
        int k;
        k = 0;
        @(negedge clk28);
        while (bus.mix_valid !== 1'b1 && k < 20) begin
            @(negedge clk28);
            k++;
        end
        check("valid_seen", {31'd0, bus.mix_valid}, 32'd1);
    endtask

    task automatic count_dac(input int cycles, output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk28);
            if (bus.dac_l === 1'b1) ones_l++;
            if (bus.dac_r === 1'b1) ones_r++;
        end
    endtask

    initial begin
        usrrst_n    = 1'b0;
        bus.ch_data = '0;
        bus.ch_vol  = '0;
        bus.ch_pan  = '0;
        bus.mute    = 1'b0;
        repeat (3) @(negedge clk28);

        check("rst_mix_l", bus.mix_l, 0);
        check("rst_mix_r", bus.mix_r, 0);
        check("rst_valid", {31'd0, bus.mix_valid}, 0);
        check("rst_dac_l", {31'd0, bus.dac_l}, 0);
        check("rst_dac_r", {31'd0, bus.dac_r}, 0);

        // Full scale: 6 * 255 = 1530 on both sides
        for (int i = 0; i < 6; i++) set_ch(i, 8'hFF, 2'd3, 2'b11);
        usrrst_n = 1'b1;
        wait_valid();
        @(negedge clk28);
        check("full_mix_l", bus.mix_l, 1530);
        check("full_mix_r", bus.mix_r, 1530);
`ifdef MIXER_SOFTMUTE_EN
        repeat (12 * 7) @(negedge clk28);
`endif
        @(negedge clk28);
        count_dac(2048, nl, nr);
        check("full_dac_l_ones", nl, 1530);
        check("full_dac_r_ones", nr, 1530);

        // Half volume, left only: 0x80 >> 1 = 64
        clear_all();
        set_ch(0, 8'h80, 2'd2, 2'b01);
        wait_valid();
        wait_valid();
        @(negedge clk28);
        check("half_mix_l", bus.mix_l, 64);
        check("half_mix_r", bus.mix_r, 0);
        repeat (2) @(negedge clk28);
        count_dac(2048, nl, nr);
        check("half_dac_l_ones", nl, 64);
        check("half_dac_r_ones", nr, 0);

        // Quarter volume, right only: 0xFF >> 2 = 63, then muted
        clear_all();
        set_ch(3, 8'hFF, 2'd1, 2'b10);
        wait_valid();
        wait_valid();
        @(negedge clk28);
        check("quarter_mix_r", bus.mix_r, 63);
        check("quarter_mix_l", bus.mix_l, 0);
        set_ch(3, 8'hFF, 2'd0, 2'b10);
        wait_valid();
        wait_valid();
        @(negedge clk28);
        check("vol0_mix_r", bus.mix_r, 0);

        // Frame timing and mid-frame input change
        clear_all();
        set_ch(1, 8'd10, 2'd3, 2'b01);
        set_ch(5, 8'd20, 2'd3, 2'b01);
        wait_valid();
        wait_valid();
        @(negedge clk28);
        check("timing_base_l", bus.mix_l, 30);
        wait_valid();
        n = 0;
        do begin
            @(negedge clk28);
            n++;
        end while (bus.mix_valid !== 1'b1 && n < 20);
        check("valid_period", n, 7);
        repeat (3) @(negedge clk28);
        set_ch(1, 8'd100, 2'd3, 2'b01);
        set_ch(5, 8'd200, 2'd3, 2'b01);
        wait_valid();
        @(negedge clk28);
        check("midframe_l", bus.mix_l, 210);
        wait_valid();
        @(negedge clk28);
        check("nextframe_l", bus.mix_l, 300);

        // Reset at scan count 4
        for (int i = 0; i < 6; i++) set_ch(i, 8'hFF, 2'd3, 2'b11);
        wait_valid();
        wait_valid();
        @(negedge clk28);
        check("pre_rst_mix_l", bus.mix_l, 1530);
        repeat (4) @(negedge clk28);
        usrrst_n = 1'b0;
        #1;
        check("midrst_mix_l", bus.mix_l, 0);
        check("midrst_mix_r", bus.mix_r, 0);
        check("midrst_valid", {31'd0, bus.mix_valid}, 0);
        check("midrst_dac_l", {31'd0, bus.dac_l}, 0);
        repeat (3) @(negedge clk28);
        check("midrst_valid_held", {31'd0, bus.mix_valid}, 0);
        usrrst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk28);
            n++;
        end while (bus.mix_valid !== 1'b1 && n < 20);
        check("first_valid_after_rst", n, 6);
        @(negedge clk28);
        check("post_rst_mix_l", bus.mix_l, 1530);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
